// File: rtl/fifo_wr_arb_if.sv
// Requester-side and FIFO-write-side signal bundle for fifo_wr_arb.
// slave = arbiter view, master = driver/monitor view.
interface fifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 16
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata_in;
  logic [GW-1:0]         grant_id;
  logic                  busy;

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata_in, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, winc, wdata_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin, packet-based arbiter sharing one FIFO write port; one IDLE cycle per grant.
// Write path is combinational so wfull stalls the granted requester in the same cycle.
module fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 16,
  parameter int BURST = 8
) (
  input  logic          wclk,
  input  logic          wrst_n,
  fifo_wr_arb_if.slave  bus
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_beat_cnt;

  logic [GW-1:0]   w_pick;
  logic [GW-1:0]   w_idx;
  logic [GW-1:0]   w_next_rr;
  logic [CW-1:0]   w_beat_inc;
  logic            w_found;
  logic            w_winc;
  logic            w_release;

  // Search starts at rr_ptr and wraps modulo NREQ; first valid requester wins.
  always_comb begin
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = GW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_winc        = 1'b0;
    bus.req_ready = '0;
    bus.wdata_in  = '0;
    if (r_state == S_BURST) begin
      bus.req_ready[r_grant_id] = ~bus.wfull;
      w_winc                    = bus.req_valid[r_grant_id] & ~bus.wfull;
      bus.wdata_in              = bus.req_data[int'(r_grant_id)*DSIZE +: DSIZE];
    end
  end

  assign bus.winc     = w_winc;
  assign bus.busy     = (r_state == S_BURST);
  assign bus.grant_id = r_grant_id;

  assign w_beat_inc = r_beat_cnt + 1'b1;
  assign w_release  = w_winc & (bus.req_last[r_grant_id] | (w_beat_inc == CW'(BURST)));
  assign w_next_rr  = (r_grant_id == GW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= S_BURST;
          end
        end
        S_BURST: begin
          // A stalled or invalid cycle leaves the grant and beat count untouched.
          if (w_winc) begin
            r_beat_cnt <= w_beat_inc;
            if (w_release) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_next_rr;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: main instance with BURST=8 plus a BURST=1 instance.
module tb_fifo_wr_arb;
  logic wclk;
  logic wrst_n;
  int   n_tests;
  int   n_fail;
  int   wr_cnt;

  fifo_wr_arb_if #(.NREQ(4), .DSIZE(16)) bus ();
  fifo_wr_arb_if #(.NREQ(4), .DSIZE(16)) bus1 ();

  fifo_wr_arb #(.NREQ(4), .DSIZE(16), .BURST(8)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  fifo_wr_arb #(.NREQ(4), .DSIZE(16), .BURST(1)) dut1 (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus1)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic smp();
    @(negedge wclk);
    wr_cnt += int'(bus.winc);
  endtask

  task automatic setd(input int i, input logic [15:0] d);
    bus.req_data[i*16 +: 16] = d;
  endtask

  task automatic clr_inputs();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    wr_cnt  = 0;
    wrst_n  = 1'b0;
    clr_inputs();
    bus1.req_valid = 4'b0010;
    bus1.req_last  = '0;
    bus1.req_data  = '0;
    bus1.req_data[16 +: 16] = 16'hB1B1;
    bus1.wfull     = 1'b0;

    // Reset state
    #2;
    chk("rst_winc", bus.winc, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wdata", bus.wdata_in, 0);
    chk("rst_gid", bus.grant_id, 0);
    cyc();
    cyc();

    // Single packet from requester 2: A,B,C
    bus.req_valid = 4'b0100;
    setd(2, 16'hA00A);
    wr_cnt = 0;
    wrst_n = 1'b1;
    smp();
    chk("sp_idle_winc", bus.winc, 0);
    chk("sp_idle_busy", bus.busy, 0);
    cyc();
    smp();
    chk("sp_a_winc", bus.winc, 1);
    chk("sp_a_data", bus.wdata_in, 16'hA00A);
    chk("sp_gid", bus.grant_id, 2);
    chk("sp_ready", bus.req_ready, 4'b0100);
    cyc();
    setd(2, 16'hB00B);
    smp();
    chk("sp_b_winc", bus.winc, 1);
    chk("sp_b_data", bus.wdata_in, 16'hB00B);
    cyc();
    setd(2, 16'hC00C);
    bus.req_last = 4'b0100;
    smp();
    chk("sp_c_winc", bus.winc, 1);
    chk("sp_c_data", bus.wdata_in, 16'hC00C);
    cyc();
    // Now IDLE; requesters 0 and 3 contend, rr_ptr = 3 must pick 3
    bus.req_valid = 4'b1001;
    bus.req_last  = 4'b1001;
    setd(0, 16'h0C00);
    setd(3, 16'h3C03);
    smp();
    chk("sp_end_busy", bus.busy, 0);
    chk("sp_end_winc", bus.winc, 0);
    chk("sp_wr_cnt", wr_cnt, 3);
    cyc();
    smp();
    chk("sp_rr_gid3", bus.grant_id, 3);
    chk("sp_rr_data3", bus.wdata_in, 16'h3C03);
    cyc();
    smp();
    chk("sp_rr_bubble", bus.winc, 0);
    cyc();
    smp();
    chk("sp_rr_wrap_gid0", bus.grant_id, 0);
    chk("sp_rr_wrap_winc", bus.winc, 1);
    cyc();

    // Round-robin with 1-beat packets; BURST=1 instance alternates too
    wrst_n = 1'b0;
    clr_inputs();
    cyc();
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    for (int i = 0; i < 4; i++) setd(i, 16'h1000 + 16'(i));
    wrst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      smp();
      chk("rr_winc", bus.winc, k % 2);
      chk("b1_winc", bus1.winc, k % 2);
      if (k % 2 == 1) begin
        chk("rr_gid", bus.grant_id, (k / 2) % 4);
        chk("rr_data", bus.wdata_in, 16'h1000 + 16'((k / 2) % 4));
        chk("b1_gid", bus1.grant_id, 1);
      end
      cyc();
    end

    // Burst cap: requester 1 streams without last, requester 0 joins mid-grant
    wrst_n = 1'b0;
    clr_inputs();
    cyc();
    bus.req_valid = 4'b0010;
    setd(1, 16'h1111);
    setd(0, 16'h0F0F);
    wrst_n = 1'b1;
    smp();
    chk("bc_idle", bus.winc, 0);
    cyc();
    bus.req_valid = 4'b0011;
    bus.req_last  = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      smp();
      chk("bc_r1_winc", bus.winc, 1);
      chk("bc_r1_gid", bus.grant_id, 1);
      cyc();
    end
    smp();
    chk("bc_cap_busy", bus.busy, 0);
    chk("bc_cap_winc", bus.winc, 0);
    cyc();
    smp();
    chk("bc_r0_gid", bus.grant_id, 0);
    chk("bc_r0_data", bus.wdata_in, 16'h0F0F);
    cyc();
    smp();
    chk("bc_bubble2", bus.winc, 0);
    cyc();
    smp();
    chk("bc_r1_resume_gid", bus.grant_id, 1);
    chk("bc_r1_resume_winc", bus.winc, 1);
    cyc();

    // Backpressure: wfull for 5 cycles after beat 2 of 4
    wrst_n = 1'b0;
    clr_inputs();
    cyc();
    bus.req_valid = 4'b0100;
    setd(2, 16'h2001);
    wr_cnt = 0;
    wrst_n = 1'b1;
    smp();
    cyc();
    smp();
    chk("bp_b1_data", bus.wdata_in, 16'h2001);
    cyc();
    setd(2, 16'h2002);
    smp();
    chk("bp_b2_winc", bus.winc, 1);
    cyc();
    bus.wfull = 1'b1;
    setd(2, 16'h2003);
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("bp_stall_winc", bus.winc, 0);
      chk("bp_stall_ready", bus.req_ready, 0);
      chk("bp_stall_busy", bus.busy, 1);
      chk("bp_stall_cnt", dut.r_beat_cnt, 2);
      cyc();
    end
    bus.wfull = 1'b0;
    smp();
    chk("bp_b3_winc", bus.winc, 1);
    chk("bp_b3_data", bus.wdata_in, 16'h2003);
    cyc();
    setd(2, 16'h2004);
    bus.req_last = 4'b0100;
    smp();
    chk("bp_b4_data", bus.wdata_in, 16'h2004);
    cyc();
    clr_inputs();
    smp();
    chk("bp_end_busy", bus.busy, 0);
    chk("bp_wr_cnt", wr_cnt, 4);
    cyc();

    // Mid-packet valid gap on requester 3 while requester 0 waits
    wrst_n = 1'b0;
    clr_inputs();
    cyc();
    bus.req_valid = 4'b1000;
    bus.req_last  = 4'b0001;
    setd(3, 16'h3001);
    setd(0, 16'h0A0A);
    wrst_n = 1'b1;
    smp();
    cyc();
    bus.req_valid = 4'b1001;
    smp();
    chk("gap_gid3", bus.grant_id, 3);
    chk("gap_b1_winc", bus.winc, 1);
    cyc();
    smp();
    chk("gap_b2_winc", bus.winc, 1);
    cyc();
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("gap_hold_winc", bus.winc, 0);
      chk("gap_hold_gid", bus.grant_id, 3);
      chk("gap_hold_busy", bus.busy, 1);
      cyc();
    end
    bus.req_valid = 4'b1001;
    bus.req_last  = 4'b1001;
    smp();
    chk("gap_last_winc", bus.winc, 1);
    chk("gap_last_gid", bus.grant_id, 3);
    cyc();
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    smp();
    chk("gap_idle_busy", bus.busy, 0);
    cyc();
    smp();
    chk("gap_r0_gid", bus.grant_id, 0);
    chk("gap_r0_winc", bus.winc, 1);
    cyc();

    // Reset mid-burst after rr_ptr has moved to 2
    wrst_n = 1'b0;
    clr_inputs();
    cyc();
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0010;
    setd(1, 16'h0001);
    wrst_n = 1'b1;
    smp();
    cyc();
    smp();
    chk("mr_r1_gid", bus.grant_id, 1);
    cyc();
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0000;
    setd(2, 16'h0002);
    smp();
    chk("mr_idle", bus.winc, 0);
    cyc();
    smp();
    cyc();
    smp();
    cyc();
    smp();
    chk("mr_b3_winc", bus.winc, 1);
    chk("mr_b3_gid", bus.grant_id, 2);
    #1;
    wrst_n = 1'b0;
    #1;
    chk("mr_async_winc", bus.winc, 0);
    chk("mr_async_ready", bus.req_ready, 0);
    chk("mr_async_busy", bus.busy, 0);
    chk("mr_async_wdata", bus.wdata_in, 0);
    cyc();
    bus.req_valid = 4'b1111;
    wrst_n = 1'b1;
    smp();
    chk("mr_post_idle", bus.winc, 0);
    cyc();
    smp();
    chk("mr_post_gid0", bus.grant_id, 0);
    chk("mr_post_winc", bus.winc, 1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
